// File: rtl/counter_sequence_checker_pkg.sv
// rtl/counter_sequence_checker_pkg.sv - shared types and LFSR constants for the counter sequence checker
package counter_sequence_checker_pkg;

  typedef enum logic {
    ST_WAIT_FIRST,
    ST_RUN
  } state_t;

  localparam int LFSR_WIDTH = 16;
  // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
  localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/counter_sequence_checker_lfsr.sv
// rtl/counter_sequence_checker_lfsr.sv - seeded 16-bit Fibonacci LFSR used to throttle s_ready
module counter_sequence_checker_lfsr
  import counter_sequence_checker_pkg::*;
#(
  parameter logic [LFSR_WIDTH-1:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic lfsr_bit
);

  logic [LFSR_WIDTH-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= SEED;
    end else if (enable) begin
      lfsr <= {lfsr[LFSR_WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign lfsr_bit = lfsr[0];

endmodule

// File: rtl/counter_sequence_checker.sv
// rtl/counter_sequence_checker.sv - sink-side checker for an incrementing counter stream
module counter_sequence_checker
  import counter_sequence_checker_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    COUNT_WIDTH  = 32,
  parameter int                    ERR_WIDTH    = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0,
  parameter bit                    AUTO_SYNC    = 1'b1,
  parameter bit                    RESYNC       = 1'b1,
  parameter bit                    READY_RANDOM = 1'b0,
  parameter logic [15:0]           LFSR_SEED    = 16'hACE1
) (
  input  logic                   reset,
  input  logic                   clk,
  input  logic                   clear,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   mismatch,
  output logic                   error_flag,
  output logic [ERR_WIDTH-1:0]   error_count,
  output logic [COUNT_WIDTH-1:0] beat_count,
  output logic [DATA_WIDTH-1:0]  expected,
  output logic [DATA_WIDTH-1:0]  first_err_data,
  output logic [DATA_WIDTH-1:0]  first_err_expected
);

  localparam state_t START_STATE = AUTO_SYNC ? ST_WAIT_FIRST : ST_RUN;
  localparam logic [DATA_WIDTH-1:0] START_EXPECTED = AUTO_SYNC ? '0 : INIT_VALUE;

  state_t state;
  logic   lfsr_bit;
  logic   accept;

  counter_sequence_checker_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .enable  (1'b1),
    .lfsr_bit(lfsr_bit)
  );

  assign accept = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= START_STATE;
      s_ready            <= 1'b0;
      mismatch           <= 1'b0;
      error_flag         <= 1'b0;
      error_count        <= '0;
      beat_count         <= '0;
      expected           <= START_EXPECTED;
      first_err_data     <= '0;
      first_err_expected <= '0;
    end else begin
      s_ready  <= READY_RANDOM ? lfsr_bit : 1'b1;
      mismatch <= 1'b0;
      // clear takes priority over a beat arriving in the same cycle
      if (clear) begin
        state              <= START_STATE;
        error_flag         <= 1'b0;
        error_count        <= '0;
        beat_count         <= '0;
        expected           <= START_EXPECTED;
        first_err_data     <= '0;
        first_err_expected <= '0;
      end else if (accept) begin
        beat_count <= beat_count + COUNT_WIDTH'(1);
        if (state == ST_WAIT_FIRST) begin
          expected <= s_data + DATA_WIDTH'(1);
          state    <= ST_RUN;
        end else if (s_data == expected) begin
          expected <= expected + DATA_WIDTH'(1);
        end else begin
          mismatch   <= 1'b1;
          error_flag <= 1'b1;
          if (error_count != '1) begin
            error_count <= error_count + ERR_WIDTH'(1);
          end
          if (!error_flag) begin
            first_err_data     <= s_data;
            first_err_expected <= expected;
          end
          expected <= RESYNC ? s_data + DATA_WIDTH'(1) : expected + DATA_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_sequence_checker.sv
// tb/tb_counter_sequence_checker.sv - scoreboard bench for two checker configurations
module tb_counter_sequence_checker;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic [DW-1:0] s_data_a = '0, s_data_b = '0;
  logic s_valid_a = 1'b0, s_valid_b = 1'b0;

  logic s_ready_a, mismatch_a, error_flag_a;
  logic [15:0] error_count_a;
  logic [31:0] beat_count_a;
  logic [DW-1:0] expected_a, fe_data_a, fe_exp_a;

  logic s_ready_b, mismatch_b, error_flag_b;
  logic [2:0] error_count_b;
  logic [31:0] beat_count_b;
  logic [DW-1:0] expected_b, fe_data_b, fe_exp_b;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // a: auto-sync, resync, random backpressure; b: fixed start 5, no resync, 3-bit error counter
  counter_sequence_checker #(
    .DATA_WIDTH(DW), .COUNT_WIDTH(32), .ERR_WIDTH(16), .INIT_VALUE(8'd0),
    .AUTO_SYNC(1'b1), .RESYNC(1'b1), .READY_RANDOM(1'b1), .LFSR_SEED(16'hACE1)
  ) dut_a (
    .reset(reset), .clk(clk), .clear(clear), .s_data(s_data_a), .s_valid(s_valid_a),
    .s_ready(s_ready_a), .mismatch(mismatch_a), .error_flag(error_flag_a),
    .error_count(error_count_a), .beat_count(beat_count_a), .expected(expected_a),
    .first_err_data(fe_data_a), .first_err_expected(fe_exp_a)
  );

  counter_sequence_checker #(
    .DATA_WIDTH(DW), .COUNT_WIDTH(32), .ERR_WIDTH(3), .INIT_VALUE(8'd5),
    .AUTO_SYNC(1'b0), .RESYNC(1'b0), .READY_RANDOM(1'b0), .LFSR_SEED(16'hACE1)
  ) dut_b (
    .reset(reset), .clk(clk), .clear(clear), .s_data(s_data_b), .s_valid(s_valid_b),
    .s_ready(s_ready_b), .mismatch(mismatch_b), .error_flag(error_flag_b),
    .error_count(error_count_b), .beat_count(beat_count_b), .expected(expected_b),
    .first_err_data(fe_data_b), .first_err_expected(fe_exp_b)
  );

  // Reference model: one entry per instance, plain integer arithmetic mod 256
  int c_auto[2]   = '{1, 0};
  int c_init[2]   = '{0, 5};
  int c_resync[2] = '{1, 0};
  int c_errmax[2] = '{65535, 7};

  bit m_sync[2];
  bit m_flag[2];
  bit m_mm[2];
  int m_exp[2], m_beats[2], m_errs[2], m_fd[2], m_fe[2];

  typedef struct {
    bit mm;
    bit flag;
    int errs;
    int beats;
    int exp;
    int fd;
    int fe;
    bit rdy_known;
    bit rdy;
  } rec_t;

  rec_t q_a[$];
  rec_t q_b[$];

  function automatic void model_step(int i, bit rst, bit clr, bit acc, int d);
    m_mm[i] = 1'b0;
    if (rst || clr) begin
      m_sync[i]  = (c_auto[i] == 0);
      m_exp[i]   = (c_auto[i] != 0) ? 0 : c_init[i];
      m_beats[i] = 0;
      m_errs[i]  = 0;
      m_flag[i]  = 1'b0;
      m_fd[i]    = 0;
      m_fe[i]    = 0;
    end else if (acc) begin
      m_beats[i]++;
      if (!m_sync[i]) begin
        m_exp[i]  = (d + 1) % 256;
        m_sync[i] = 1'b1;
      end else if (d == m_exp[i]) begin
        m_exp[i] = (m_exp[i] + 1) % 256;
      end else begin
        m_mm[i] = 1'b1;
        if (m_errs[i] < c_errmax[i]) m_errs[i]++;
        if (!m_flag[i]) begin
          m_fd[i] = d;
          m_fe[i] = m_exp[i];
        end
        m_flag[i] = 1'b1;
        m_exp[i]  = (((c_resync[i] != 0) ? d : m_exp[i]) + 1) % 256;
      end
    end
  endfunction

  function automatic rec_t snap(int i, bit rk, bit r);
    rec_t t;
    t.mm = m_mm[i]; t.flag = m_flag[i]; t.errs = m_errs[i]; t.beats = m_beats[i];
    t.exp = m_exp[i]; t.fd = m_fd[i]; t.fe = m_fe[i]; t.rdy_known = rk; t.rdy = r;
    return t;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Predictor: inputs are stable here; predicts outputs after the coming rising edge
  initial begin
    bit acc_a, acc_b;
    forever begin
      @(negedge clk);
      #2;
      acc_a = s_valid_a && s_ready_a;
      acc_b = s_valid_b && s_ready_b;
      model_step(0, reset, clear, acc_a, int'(s_data_a));
      model_step(1, reset, clear, acc_b, int'(s_data_b));
      q_a.push_back(snap(0, reset, 1'b0));
      q_b.push_back(snap(1, 1'b1, !reset));
    end
  end

  // Monitor: compares DUT outputs against the queued prediction each cycle
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        r = q_a.pop_front();
        chk("a_mismatch", mismatch_a, r.mm);
        chk("a_error_flag", error_flag_a, r.flag);
        chk("a_error_count", error_count_a, r.errs);
        chk("a_beat_count", beat_count_a, r.beats);
        chk("a_expected", expected_a, r.exp);
        chk("a_first_err_data", fe_data_a, r.fd);
        chk("a_first_err_expected", fe_exp_a, r.fe);
        if (r.rdy_known) chk("a_s_ready_reset", s_ready_a, r.rdy);
      end
      if (q_b.size() > 0) begin
        r = q_b.pop_front();
        chk("b_mismatch", mismatch_b, r.mm);
        chk("b_error_flag", error_flag_b, r.flag);
        chk("b_error_count", error_count_b, r.errs);
        chk("b_beat_count", beat_count_b, r.beats);
        chk("b_expected", expected_b, r.exp);
        chk("b_first_err_data", fe_data_b, r.fd);
        chk("b_first_err_expected", fe_exp_b, r.fe);
        chk("b_s_ready", s_ready_b, r.rdy);
      end
    end
  end

  int ready_hi = 0, ready_lo = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (s_ready_a) ready_hi++;
      else ready_lo++;
    end
  end

  // Drive one beat and hold it until the selected instance accepts it
  task automatic send(int i, int d);
    bit rdy;
    int waited = 0;
    if (i == 0) begin s_valid_a = 1'b1; s_data_a = DW'(d); end
    else        begin s_valid_b = 1'b1; s_data_b = DW'(d); end
    forever begin
      @(negedge clk);
      rdy = (i == 0) ? s_ready_a : s_ready_b;
      @(posedge clk);
      #1;
      if (rdy) break;
      waited++;
      if (waited > 200) begin
        chk("send_timeout", waited, 0);
        break;
      end
    end
  endtask

  task automatic idle(int cycles);
    s_valid_a = 1'b0;
    s_valid_b = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cur, v;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // a: auto-sync on 100..199
    for (int k = 100; k < 200; k++) send(0, k);
    idle(2);
    chk("a_plan_beats", beat_count_a, 100);
    chk("a_plan_expected", expected_a, 200);
    chk("a_plan_errors", error_count_a, 0);
    chk("a_plan_flag", error_flag_a, 0);

    // a: wrap through 0xFE, 0xFF, 0x00, 0x01
    for (int k = 200; k < 258; k++) send(0, k % 256);
    idle(1);
    chk("a_wrap_errors", error_count_a, 0);
    chk("a_wrap_expected", expected_a, 2);

    // a: long random run with occasional corrupted words
    cur = 2;
    for (int k = 0; k < 600; k++) begin
      v = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : cur;
      send(0, v);
      cur = (v + 1) % 256;
    end
    idle(2);

    // clear together with a valid beat, then restart at 50
    s_valid_a = 1'b1;
    s_data_a = 8'd77;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    idle(1);
    chk("a_clear_beats", beat_count_a, 0);
    chk("a_clear_errors", error_count_a, 0);
    for (int k = 50; k < 81; k++) send(0, k);
    idle(1);
    chk("a_restart_errors", error_count_a, 0);
    chk("a_restart_beats", beat_count_a, 31);
    chk("a_restart_expected", expected_a, 81);

    // reset mid-stream with a beat in flight
    s_valid_a = 1'b1;
    s_data_a = 8'd82;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 10; k < 30; k++) send(0, k);
    idle(1);
    chk("a_post_reset_beats", beat_count_a, 20);

    // b: 5,6,9,10 without resync
    send(1, 5); send(1, 6); send(1, 9); send(1, 10);
    idle(1);
    chk("b_plan_errors", error_count_b, 2);
    chk("b_plan_expected", expected_b, 9);
    chk("b_plan_first_data", fe_data_b, 9);
    chk("b_plan_first_exp", fe_exp_b, 7);
    chk("b_plan_beats", beat_count_b, 4);

    // b: drive the 3-bit error counter into saturation
    for (int k = 0; k < 20; k++) send(1, 0);
    idle(1);
    chk("b_sat_errors", error_count_b, 7);
    chk("b_sat_first_data", fe_data_b, 9);

    // b: random data after a clear
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    for (int k = 0; k < 200; k++) send(1, int'($urandom_range(0, 255)));
    idle(3);

    chk("a_ready_high_seen", ready_hi > 100, 1);
    chk("a_ready_low_seen", ready_lo > 100, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    chk("global_timeout", 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sequence_checker.md
# counter_sequence_checker

Stream-side checker that consumes a valid/ready stream of incrementing counter words and verifies the sequence. It is the receiving counterpart of the free-running counter generators used in simulation top-levels. It sits at the sink end of a DUT data path, both in benches and in on-chip self-test builds. It applies optional pseudo-random backpressure, tracks the expected value, counts beats and mismatches, and captures the first failure for debug.

## Interface
- DATA_WIDTH, 32, width of checked word and expected counter
- COUNT_WIDTH, 32, width of beat counter
- ERR_WIDTH, 16, width of saturating error counter
- INIT_VALUE, 0, expected value of first beat when AUTO_SYNC=0
- AUTO_SYNC, 1, 1: first accepted beat after reset/clear defines the sequence start
- RESYNC, 1, 1: after a mismatch, next expected = received+1; 0: next expected = expected+1
- READY_RANDOM, 0, 1: s_ready throttled by LFSR; 0: s_ready held high
- LFSR_SEED, 16'hACE1, nonzero 16-bit seed for throttle LFSR
- reset  input  1  synchronous, active-high reset
- clk  input  1  single clock; all state updates on rising edge
- clear  input  1  synchronous soft clear of counters, flags and sync state
- s_data  input  DATA_WIDTH  stream word
- s_valid  input  1  stream word valid
- s_ready  output  1  checker accepts word (registered)
- mismatch  output  1  one-cycle pulse, one cycle after a failing beat
- error_flag  output  1  sticky, set on first mismatch
- error_count  output  ERR_WIDTH  mismatches, saturates at all-ones
- beat_count  output  COUNT_WIDTH  accepted beats, wraps
- expected  output  DATA_WIDTH  next expected value
- first_err_data  output  DATA_WIDTH  received word of first mismatch
- first_err_expected  output  DATA_WIDTH  expected word of first mismatch

## Operation
- Beat accepted when s_valid && s_ready at rising edge.
- States: ST_WAIT_FIRST, ST_RUN. Reset/clear enter ST_WAIT_FIRST if AUTO_SYNC=1, else ST_RUN with expected=INIT_VALUE.
- ST_WAIT_FIRST: accepted beat → expected = s_data+1, beat_count+1, no compare, go ST_RUN.
- ST_RUN, beat with s_data==expected: expected+1, beat_count+1.
- ST_RUN, beat with s_data!=expected: mismatch pulse, error_count+1 (saturating), error_flag set. If error_flag was 0, capture first_err_data/first_err_expected. Next expected per RESYNC. Remain in ST_RUN.
- Arithmetic modulo 2^DATA_WIDTH: expected all-ones → 0 is a pass, not an error.
- READY_RANDOM=1: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle; s_ready = bit0. READY_RANDOM=0: s_ready=1 from first cycle after reset.
- clear and a beat in the same cycle: clear wins, beat discarded and not counted; LFSR not reseeded by clear.
- Reset mid-stream: all state lost; an in-flight beat is not counted.

## Timing
- Reset values: s_ready=0, mismatch=0, error_flag=0, error_count=0, beat_count=0, expected=(AUTO_SYNC ? 0 : INIT_VALUE), first_err_*=0, LFSR=LFSR_SEED.
- s_ready first rises the cycle after reset deasserts (random mode: when LFSR bit0 is 1).
- All status outputs registered; updated in cycle N+1 for a beat accepted at edge N.
- s_ready does not depend combinationally on s_valid.

## Structure
- Package counter_sequence_checker_pkg: state enum (ST_WAIT_FIRST, ST_RUN), LFSR width/tap constants.
- Sub-module counter_sequence_checker_lfsr: seeded 16-bit LFSR with enable; output bit drives s_ready in random mode.
- Top: FSM, compare, counters and capture registers.

## Test plan
- Reset, AUTO_SYNC=1, send 100, 101, … 199 → beat_count=100, error_count=0, expected=200, error_flag=0.
- AUTO_SYNC=0, INIT_VALUE=5, send 5,6,9,10 with RESYNC=1 → one mismatch pulse, first_err_data=9, first_err_expected=7, error_count=1, expected=11.
- Same stream with RESYNC=0 → error_count=2, expected=9.
- DATA_WIDTH=8, send 0xFE,0xFF,0x00,0x01 → no errors, expected=0x02.
- READY_RANDOM=1, source holds s_valid=1 for 1000 beats → s_ready toggles, data stable while stalled, beat_count=1000, no errors.
- Assert clear together with a beat mid-stream, then restart at 50 → beat discarded, counters 0, state ST_WAIT_FIRST, 50 accepted as sync, no error.
